complex_acc: RTL

- Downstream consumer of complex_nr_mult_1. Accumulates a frame of signed complex products (re/im, 16 bit each) into wide accumulators.
- Presents one complex sum per frame on a valid/ready output port.
- Typical use: complex dot product / correlation tap sum after the multiplier.

---
 rtl/complex_acc.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/complex_acc.sv
// complex_acc: accumulates a frame of signed complex products into wide
// accumulators and presents one complex sum per frame on a valid/ready port.
// A frame ends after LEN transfers or on a transfer flagged with in_last.
// Optional build macro COMPLEX_ACC_SAT_EN: when defined, accumulators
// saturate on overflow. When undefined, they wrap modulo 2^ACC_W.
module complex_acc #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 24,
  parameter int LEN   = 4
) (
  input  logic                       clk,
  input  logic                       sw_rst,
  input  logic                       in_val,
  output logic                       in_rdy,
  input  logic signed [IN_W-1:0]     in_re,
  input  logic signed [IN_W-1:0]     in_im,
  input  logic                       in_last,
  output logic                       out_val,
  input  logic                       out_rdy,
  output logic signed [ACC_W-1:0]    out_re,
  output logic signed [ACC_W-1:0]    out_im,
  output logic [$clog2(LEN+1)-1:0]   out_cnt,
  output logic                       out_ovf
);

  localparam int CNT_W  = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int OCNT_W = $clog2(LEN+1);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic signed [ACC_W-1:0]   acc_re;
  logic signed [ACC_W-1:0]   acc_im;
  logic [CNT_W-1:0]          count;
  logic                      ovf_flag;

  logic                      xfer;
  logic                      frame_end;
  logic signed [ACC_W-1:0]   ext_re;
  logic signed [ACC_W-1:0]   ext_im;
  logic signed [ACC_W-1:0]   sum_re;
  logic signed [ACC_W-1:0]   sum_im;
  logic                      ovf_re;
  logic                      ovf_im;
  logic signed [ACC_W-1:0]   nxt_re;
  logic signed [ACC_W-1:0]   nxt_im;

  // Handshake decode and FSM next state: only ACC accepts beats, only OUT offers a sum.
  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    out_val   = 1'b0;
    xfer      = 1'b0;
    frame_end = 1'b0;
    case (state)
      ST_ACC: begin
        in_rdy    = 1'b1;
        xfer      = in_val;
        frame_end = in_val && ((count == CNT_W'(LEN-1)) || in_last);
        if (frame_end) begin
          state_nxt = ST_OUT;
        end
      end
      ST_OUT: begin
        out_val = 1'b1;
        if (out_rdy) begin
          state_nxt = ST_ACC;
        end
      end
      default: state_nxt = ST_ACC;
    endcase
  end

  // Sign-extended addends gated to zero off-transfer so idle X data never reaches the adders' results.
  always_comb begin
    ext_re = '0;
    ext_im = '0;
    if (xfer) begin
      ext_re = ACC_W'(in_re);
      ext_im = ACC_W'(in_im);
    end
  end

  // Wrapping sums with overflow flagged when same-sign operands give an opposite-sign result.
  always_comb begin
    sum_re = acc_re + ext_re;
    sum_im = acc_im + ext_im;
    ovf_re = (acc_re[ACC_W-1] == ext_re[ACC_W-1]) && (sum_re[ACC_W-1] != acc_re[ACC_W-1]);
    ovf_im = (acc_im[ACC_W-1] == ext_im[ACC_W-1]) && (sum_im[ACC_W-1] != acc_im[ACC_W-1]);
  end

  // Next accumulator value: clamp toward the operands' sign on overflow, otherwise take the wrapped sum.
  always_comb begin
    nxt_re = sum_re;
    nxt_im = sum_im;
`ifdef COMPLEX_ACC_SAT_EN
    if (ovf_re) begin
      nxt_re = acc_re[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end
    if (ovf_im) begin
      nxt_im = acc_im[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (sw_rst) begin
      state <= ST_ACC;
    end else begin
      state <= state_nxt;
    end
  end

  // Accumulate on each transfer, capture the result on the frame's last beat, clear after the output handshake.
  always_ff @(posedge clk) begin
    if (sw_rst) begin
      acc_re   <= '0;
      acc_im   <= '0;
      count    <= '0;
      ovf_flag <= 1'b0;
      out_re   <= '0;
      out_im   <= '0;
      out_cnt  <= '0;
      out_ovf  <= 1'b0;
    end else begin
      if (xfer) begin
        acc_re   <= nxt_re;
        acc_im   <= nxt_im;
        count    <= count + CNT_W'(1);
        ovf_flag <= ovf_flag | ovf_re | ovf_im;
      end
      if (frame_end) begin
        out_re  <= nxt_re;
        out_im  <= nxt_im;
        out_cnt <= OCNT_W'(count) + OCNT_W'(1);
        out_ovf <= ovf_flag | ovf_re | ovf_im;
      end
      if (out_val && out_rdy) begin
        acc_re   <= '0;
        acc_im   <= '0;
        count    <= '0;
        ovf_flag <= 1'b0;
      end
    end
  end

endmodule
